// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station with CDB wakeup, lowest-index select and tag alignment
module alu_reservation_station #(
  parameter int DatapathWidth     = 2,
  parameter int AluOperationWidth = 5,
  parameter int NumEntries        = 4,
  parameter int TagWidth          = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         dispatch_valid_i,
  output logic                         dispatch_ready_o,
  input  logic [AluOperationWidth-1:0] dispatch_operation_i,
  input  logic                         dispatch_src1_valid_i,
  input  logic                         dispatch_src2_valid_i,
  input  logic [DatapathWidth-1:0]     dispatch_src1_i,
  input  logic [DatapathWidth-1:0]     dispatch_src2_i,
  input  logic [TagWidth-1:0]          dispatch_src1_tag_i,
  input  logic [TagWidth-1:0]          dispatch_src2_tag_i,
  input  logic [DatapathWidth-1:0]     dispatch_immediate_i,
  input  logic [DatapathWidth-1:0]     dispatch_pc_i,
  input  logic [TagWidth-1:0]          dispatch_dest_tag_i,
  input  logic                         cdb_valid_i,
  input  logic [TagWidth-1:0]          cdb_tag_i,
  input  logic [DatapathWidth-1:0]     cdb_value_i,
  output logic                         issue_valid_o,
  output logic [AluOperationWidth-1:0] operation_o,
  output logic [DatapathWidth-1:0]     operand1_o,
  output logic [DatapathWidth-1:0]     operand2_o,
  output logic [DatapathWidth-1:0]     immediate_o,
  output logic [DatapathWidth-1:0]     pc_o,
  output logic                         result_valid_o,
  output logic [TagWidth-1:0]          result_tag_o
);

  localparam int IdxWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  // Per-entry state
  logic [NumEntries-1:0]        busy_q;
  logic [NumEntries-1:0]        src1_rdy_q;
  logic [NumEntries-1:0]        src2_rdy_q;
  logic [AluOperationWidth-1:0] op_q       [NumEntries];
  logic [DatapathWidth-1:0]     imm_q      [NumEntries];
  logic [DatapathWidth-1:0]     pc_q       [NumEntries];
  logic [TagWidth-1:0]          dest_q     [NumEntries];
  logic [DatapathWidth-1:0]     src1_val_q [NumEntries];
  logic [DatapathWidth-1:0]     src2_val_q [NumEntries];
  logic [TagWidth-1:0]          src1_tag_q [NumEntries];
  logic [TagWidth-1:0]          src2_tag_q [NumEntries];

  // Issue stage registers
  logic                         issue_valid_q;
  logic [AluOperationWidth-1:0] issue_op_q;
  logic [DatapathWidth-1:0]     issue_op1_q;
  logic [DatapathWidth-1:0]     issue_op2_q;
  logic [DatapathWidth-1:0]     issue_imm_q;
  logic [DatapathWidth-1:0]     issue_pc_q;
  logic [TagWidth-1:0]          issue_tag_q;

  // Result-alignment stage registers
  logic                         result_valid_q;
  logic [TagWidth-1:0]          result_tag_q;

  logic                         sel_found;
  logic [IdxWidth-1:0]          sel_idx;
  logic                         free_found;
  logic [IdxWidth-1:0]          free_idx;
  logic                         dispatch_fire;
  logic                         disp_src1_rdy;
  logic                         disp_src2_rdy;
  logic [DatapathWidth-1:0]     disp_src1_val;
  logic [DatapathWidth-1:0]     disp_src2_val;

  // Priority pickers: lowest ready entry for issue, lowest free entry for dispatch.
  // Both look only at registered state, so a same-cycle wakeup or issue is not seen.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (busy_q[i] && src1_rdy_q[i] && src2_rdy_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IdxWidth'(i);
      end
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxWidth'(i);
      end
    end
  end

  assign dispatch_ready_o = free_found;
  assign dispatch_fire    = dispatch_valid_i && free_found;

  // Dispatch-cycle bypass: a source whose producer broadcasts this very cycle is captured directly
  always_comb begin
    disp_src1_rdy = dispatch_src1_valid_i ||
                    (cdb_valid_i && (cdb_tag_i == dispatch_src1_tag_i));
    disp_src2_rdy = dispatch_src2_valid_i ||
                    (cdb_valid_i && (cdb_tag_i == dispatch_src2_tag_i));
    disp_src1_val = dispatch_src1_valid_i ? dispatch_src1_i : cdb_value_i;
    disp_src2_val = dispatch_src2_valid_i ? dispatch_src2_i : cdb_value_i;
  end

  // Entry array: wakeup of pending sources, freeing the selected entry, writing the dispatched op
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      for (int i = 0; i < NumEntries; i++) begin
        op_q[i]       <= '0;
        imm_q[i]      <= '0;
        pc_q[i]       <= '0;
        dest_q[i]     <= '0;
        src1_val_q[i] <= '0;
        src2_val_q[i] <= '0;
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
      end
    end else if (flush_i) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        if (busy_q[i] && cdb_valid_i) begin
          if (!src1_rdy_q[i] && (src1_tag_q[i] == cdb_tag_i)) begin
            src1_rdy_q[i] <= 1'b1;
            src1_val_q[i] <= cdb_value_i;
          end
          if (!src2_rdy_q[i] && (src2_tag_q[i] == cdb_tag_i)) begin
            src2_rdy_q[i] <= 1'b1;
            src2_val_q[i] <= cdb_value_i;
          end
        end
      end
      if (sel_found) begin
        busy_q[sel_idx] <= 1'b0;
      end
      // The free entry is never the selected one, since selection only picks busy entries
      if (dispatch_fire) begin
        busy_q[free_idx]     <= 1'b1;
        op_q[free_idx]       <= dispatch_operation_i;
        imm_q[free_idx]      <= dispatch_immediate_i;
        pc_q[free_idx]       <= dispatch_pc_i;
        dest_q[free_idx]     <= dispatch_dest_tag_i;
        src1_rdy_q[free_idx] <= disp_src1_rdy;
        src2_rdy_q[free_idx] <= disp_src2_rdy;
        src1_val_q[free_idx] <= disp_src1_val;
        src2_val_q[free_idx] <= disp_src2_val;
        src1_tag_q[free_idx] <= dispatch_src1_tag_i;
        src2_tag_q[free_idx] <= dispatch_src2_tag_i;
      end
    end
  end

  // Issue registers feeding the ALU; data holds its last value when nothing is selected
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_op1_q   <= '0;
      issue_op2_q   <= '0;
      issue_imm_q   <= '0;
      issue_pc_q    <= '0;
      issue_tag_q   <= '0;
    end else if (flush_i) begin
      issue_valid_q <= 1'b0;
    end else begin
      issue_valid_q <= sel_found;
      if (sel_found) begin
        issue_op_q  <= op_q[sel_idx];
        issue_op1_q <= src1_val_q[sel_idx];
        issue_op2_q <= src2_val_q[sel_idx];
        issue_imm_q <= imm_q[sel_idx];
        issue_pc_q  <= pc_q[sel_idx];
        issue_tag_q <= dest_q[sel_idx];
      end
    end
  end

  // Delay valid and destination tag by the ALU's one registered stage so they line up with its result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_valid_q <= 1'b0;
      result_tag_q   <= '0;
    end else if (flush_i) begin
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= issue_valid_q;
      result_tag_q   <= issue_tag_q;
    end
  end

  assign issue_valid_o  = issue_valid_q;
  assign operation_o    = issue_op_q;
  assign operand1_o     = issue_op1_q;
  assign operand2_o     = issue_op2_q;
  assign immediate_o    = issue_imm_q;
  assign pc_o           = issue_pc_q;
  assign result_valid_o = result_valid_q;
  assign result_tag_o   = result_tag_q;

endmodule
